// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the ALU share arbiter.
// Included by every file of the block; no configuration macros apply here.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_XOR  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_MUL  = 4'b0101,
        OP_ADDI = 4'b0110,
        OP_SRAI = 4'b0111,
        OP_ADDR = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant among valid requests, pointer moves
// to the other requester on every accepted grant.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // prio_q = 1 favours req1 when both request
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
        prio_d = prio_q;
        if (accept_i) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters; IDLE -> EXEC -> RESP per command.
// Define ALU_MUL_MULTICYCLE_EN to stretch EXEC to MUL_CYCLES for OP_MUL.
//
// state   | meaning
// IDLE    | ready offered to the granted requester, waiting for a handshake
// EXEC    | operands on alu_*; result captured on the last EXEC cycle
// RESP    | one-cycle rsp_valid pulse to the recorded requester
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [3:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [3:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_data_o,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_data_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    input  logic [31:0] alu_data_i,
    output logic        busy_o
);

    if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_mul_cycles_range
        $error("MUL_CYCLES must be within 2..15");
    end

    state_e      state_q;
    logic        idx_q;
    logic [3:0]  ctrl_q;
    logic [31:0] d1_q;
    logic [31:0] d2_q;
    logic [31:0] res_q;

    logic [1:0]  gnt;
    logic        idle;
    logic        hs;
    logic        hs_idx;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        exec_last;

    rr_arbiter2 u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    ({req1_valid_i, req0_valid_i}),
        .accept_i (hs),
        .gnt_o    (gnt)
    );

    assign idle   = (state_q == ST_IDLE);
    assign hs     = idle & (req0_valid_i | req1_valid_i) & ~rst_i;
    assign hs_idx = gnt[1];
    assign sel_op = hs_idx ? req1_op_i : req0_op_i;
    assign sel_a  = hs_idx ? req1_a_i  : req0_a_i;
    assign sel_b  = hs_idx ? req1_b_i  : req0_b_i;

`ifdef ALU_MUL_MULTICYCLE_EN
    logic [CNT_W-1:0] cnt_q;
    assign exec_last = (cnt_q == '0);
`else
    assign exec_last = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= 1'b0;
            ctrl_q  <= 4'b0000;
            d1_q    <= '0;
            d2_q    <= '0;
            res_q   <= '0;
`ifdef ALU_MUL_MULTICYCLE_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        state_q <= ST_EXEC;
                        idx_q   <= hs_idx;
                        ctrl_q  <= sel_op;
                        d1_q    <= sel_a;
                        d2_q    <= sel_b;
`ifdef ALU_MUL_MULTICYCLE_EN
                        cnt_q   <= (sel_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
`endif
                    end
                end
                ST_EXEC: begin
                    if (exec_last) begin
                        res_q   <= alu_data_i;
                        state_q <= ST_RESP;
                    end
`ifdef ALU_MUL_MULTICYCLE_EN
                    else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
`endif
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req0_ready_o = idle & gnt[0];
    assign req1_ready_o = idle & gnt[1];
    assign rsp0_valid_o = (state_q == ST_RESP) & ~idx_q;
    assign rsp1_valid_o = (state_q == ST_RESP) & idx_q;
    assign rsp0_data_o  = res_q;
    assign rsp1_data_o  = res_q;
    assign alu_ctrl_o   = ctrl_q;
    assign alu_data1_o  = d1_q;
    assign alu_data2_o  = d2_q;
    assign busy_o       = ~idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random traffic
// against a transaction-level model (response cycle, data, next-free cycle).
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int MULC = 3;
`ifdef ALU_MUL_MULTICYCLE_EN
    localparam int MUL_LAT = 1 + MULC;
`else
    localparam int MUL_LAT = 2;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [3:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic [31:0] rsp0_data_o, rsp1_data_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    alu_share_arbiter #(.MUL_CYCLES(MULC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o),
        .alu_ctrl_o(alu_ctrl_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
        .alu_data_i(alu_data_i), .busy_o(busy_o)
    );

    function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_ADDI: return a + b;
            OP_SRAI: return $signed(a) >>> b[4:0];
            OP_ADDR: return a + b;
            default: return ~a;
        endcase
    endfunction

    assign alu_data_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // transaction-level reference
    int          cyc, free_at, pend_cyc;
    bit          pend_v, pend_idx, favour;
    logic [31:0] pend_data, res_exp, e_d1, e_d2;
    logic [3:0]  e_ctrl;

    task automatic step(input bit v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit rst);
        bit idle, g, rsp_now;
        int lat;
        @(posedge clk_i);
        #1;
        cyc++;
        rsp_now = pend_v && (cyc == pend_cyc);
        if (rsp_now) res_exp = pend_data;
        check("busy", busy_o, cyc < free_at);
        check("rsp0_valid", rsp0_valid_o, rsp_now && !pend_idx);
        check("rsp1_valid", rsp1_valid_o, rsp_now && pend_idx);
        check("rsp0_data", rsp0_data_o, res_exp);
        check("rsp1_data", rsp1_data_o, res_exp);
        check("alu_ctrl", alu_ctrl_o, e_ctrl);
        check("alu_data1", alu_data1_o, e_d1);
        check("alu_data2", alu_data2_o, e_d2);

        req0_valid_i = v0; req0_op_i = o0; req0_a_i = a0; req0_b_i = b0;
        req1_valid_i = v1; req1_op_i = o1; req1_a_i = a1; req1_b_i = b1;
        rst_i = rst;
        #1;
        idle = (cyc >= free_at);
        g = (v0 && v1) ? favour : v1;
        check("req0_ready", req0_ready_o, idle && (v0 || v1) && !g);
        check("req1_ready", req1_ready_o, idle && (v0 || v1) && g);

        if (rst) begin
            pend_v = 0; free_at = cyc + 1; favour = 0;
            e_ctrl = '0; e_d1 = '0; e_d2 = '0; res_exp = '0;
        end else if (idle && (v0 || v1)) begin
            e_ctrl = g ? o1 : o0;
            e_d1   = g ? a1 : a0;
            e_d2   = g ? b1 : b0;
            lat = (e_ctrl == OP_MUL) ? MUL_LAT : 2;
            pend_v = 1; pend_idx = g; pend_cyc = cyc + lat;
            pend_data = alu_fn(e_ctrl, e_d1, e_d2);
            free_at = cyc + lat + 1;
            favour = !g;
        end
    endtask

    task automatic idle_step();
        step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        rst_i = 1; req0_valid_i = 0; req1_valid_i = 0;
        req0_op_i = '0; req0_a_i = '0; req0_b_i = '0;
        req1_op_i = '0; req1_a_i = '0; req1_b_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;
        cyc = 0; free_at = 0; pend_v = 0; pend_idx = 0; pend_cyc = 0; favour = 0;
        pend_data = '0; res_exp = '0; e_ctrl = '0; e_d1 = '0; e_d2 = '0;

        // ADD 5+7 on req0
        step(1, OP_ADD, 32'd5, 32'd7, 0, 4'h0, 32'h0, 32'h0, 0);
        check("d_add_ready0", req0_ready_o, 1);
        idle_step();
        idle_step();
        check("d_add_rsp0_valid", rsp0_valid_o, 1);
        check("d_add_rsp0_data", rsp0_data_o, 32'd12);
        check("d_add_rsp1_valid", rsp1_valid_o, 0);
        idle_step();

        // both valid from reset: req0, req1, req0
        for (int i = 0; i < 8; i++) begin
            step(1, OP_SUB, 32'd10, 32'd3, 1, OP_XOR, 32'hF0, 32'h0F, i == 0);
            if (i == 3) begin
                check("d_rr_first_valid", rsp0_valid_o, 1);
                check("d_rr_first_data", rsp0_data_o, 32'd7);
            end
            if (i == 6) begin
                check("d_rr_second_valid", rsp1_valid_o, 1);
                check("d_rr_second_data", rsp1_data_o, 32'hFF);
            end
            if (i == 7) check("d_rr_third_ready0", req0_ready_o, 1);
        end
        for (int i = 0; i < 3; i++) idle_step();

        // MUL 6*7
        step(1, OP_MUL, 32'd6, 32'd7, 0, 4'h0, 32'h0, 32'h0, 0);
        for (int j = 1; j <= 5; j++) begin
            idle_step();
            if (j == MUL_LAT) begin
                check("d_mul_valid", rsp0_valid_o, 1);
                check("d_mul_data", rsp0_data_o, 32'd42);
            end
        end

        // reset while req1 SRAI is in EXEC
        step(0, 4'h0, 32'h0, 32'h0, 1, OP_SRAI, 32'h8000_0000, 32'd4, 0);
        step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
        idle_step();
        check("d_rst_busy", busy_o, 0);
        check("d_rst_rsp1_valid", rsp1_valid_o, 0);
        check("d_rst_ctrl", alu_ctrl_o, 32'h0);
        check("d_rst_data1", alu_data1_o, 32'h0);
        check("d_rst_result", rsp1_data_o, 32'h0);
        idle_step();
        check("d_rst_no_late_pulse", rsp1_valid_o, 0);

        // req1 toggles while req0 is busy
        step(1, OP_AND, 32'hFF00, 32'h0FF0, 0, 4'h0, 32'h0, 32'h0, 0);
        step(0, 4'h0, 32'h0, 32'h0, 1, OP_ADD, 32'd1, 32'd2, 0);
        check("d_busy_ready1", req1_ready_o, 0);
        step(0, 4'h0, 32'h0, 32'h0, 0, OP_ADD, 32'd1, 32'd2, 0);
        step(0, 4'h0, 32'h0, 32'h0, 1, OP_ADD, 32'd1, 32'd2, 0);
        check("d_idle_ready1", req1_ready_o, 1);
        for (int i = 0; i < 3; i++) idle_step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] o0, o1;
            o0 = ($urandom_range(0, 3) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
            o1 = ($urandom_range(0, 3) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
            step($urandom_range(0, 1) == 1, o0, $urandom, $urandom,
                 $urandom_range(0, 1) == 1, o1, $urandom, $urandom,
                 $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
